// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter for the shared system bus with grant-wait and transfer watchdogs.
// Optional macro ARB_LOCK_EN: a locked owner keeps the bus across back-to-back transactions.
module bus_arbiter_rr #(
  parameter int unsigned NUM_MASTERS       = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 255,
  parameter int unsigned GRANT_WAIT_CYCLES = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] bus_request,
  output logic [NUM_MASTERS-1:0] bus_grant,
  input  logic                   begin_transaction,
  input  logic                   end_transaction,
  input  logic                   data_valid,
  input  logic                   bus_error,
  input  logic                   lock,
  output logic                   arb_error,
  output logic [2:0]             owner_id,
  output logic                   bus_busy
);

  localparam int unsigned PTR_W = $clog2(NUM_MASTERS);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW_W  = $clog2(GRANT_WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANTED,
    S_TRANSFER
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [PTR_W-1:0]       winner, ptr_after;
  logic [TO_W-1:0]        act_q, act_d;
  logic [GW_W-1:0]        wait_q, wait_d;
  logic [NUM_MASTERS-1:0] grant_d;
  logic                   busy_d, arb_error_d;
  logic                   found, release_bus, abort, owner_req, retain;
  int unsigned            idx;

  assign owner_id  = 3'(owner_q);
  assign owner_req = bus_request[owner_q];
  assign ptr_after = (owner_q == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner_q + PTR_W'(1);

`ifdef ARB_LOCK_EN
  assign retain = end_transaction & ~bus_error & lock & owner_req;
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign retain      = 1'b0;
`endif

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && bus_request[PTR_W'(idx)]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = bus_grant;
    busy_d      = bus_busy;
    wait_d      = wait_q;
    act_d       = act_q;
    release_bus = 1'b0;
    abort       = 1'b0;
    arb_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        act_d  = '0;
        if (found) begin
          state_d         = S_GRANTED;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          busy_d          = 1'b1;
        end
      end
      S_GRANTED: begin
        if (begin_transaction) begin
          state_d = S_TRANSFER;
          act_d   = '0;
        end else if (!owner_req) begin
          release_bus = 1'b1;
        end else if (wait_q == GW_W'(GRANT_WAIT_CYCLES - 1)) begin
          release_bus = 1'b1;
          abort       = 1'b1;
        end else begin
          wait_d = wait_q + GW_W'(1);
        end
      end
      S_TRANSFER: begin
        // Termination outranks both activity and the watchdog on the same edge.
        if (end_transaction || bus_error) begin
          if (retain) begin
            state_d = S_GRANTED;
            wait_d  = '0;
          end else begin
            release_bus = 1'b1;
          end
        end else if (begin_transaction || data_valid) begin
          act_d = '0;
        end else if (act_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          release_bus = 1'b1;
          abort       = 1'b1;
        end else begin
          act_d = act_q + TO_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Every release hands priority to the master after the outgoing owner.
    if (release_bus) begin
      state_d = S_IDLE;
      grant_d = '0;
      busy_d  = 1'b0;
      owner_d = '0;
      ptr_d   = ptr_after;
    end
    arb_error_d = abort;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      wait_q    <= '0;
      act_q     <= '0;
      bus_grant <= '0;
      bus_busy  <= 1'b0;
      arb_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      wait_q    <= wait_d;
      act_q     <= act_d;
      bus_grant <= grant_d;
      bus_busy  <= busy_d;
      arb_error <= arb_error_d;
    end
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Round-robin arbiter and watchdog for the shared system bus driven by the CPU, the custom-instruction DMA (newDMA) and other bus masters. It collects per-master bus_request lines and issues a one-hot bus_grant. It tracks the bus transaction handshake (begin_transaction / end_transaction / bus_error) to decide when ownership may change. It aborts transfers that hang, signalling an error to the owner.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8); index 0 has the highest first-pass priority after reset.
TIMEOUT_CYCLES, 255, max cycles in TRANSFER without begin/data_valid/end activity before abort (1..65535).
GRANT_WAIT_CYCLES, 15, max cycles a granted master may wait before asserting begin_transaction.

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
bus_request  in  NUM_MASTERS  per-master request, level, held until done
bus_grant  out  NUM_MASTERS  one-hot (or zero) grant, registered
begin_transaction  in  1  bus begin strobe from current owner
end_transaction  in  1  bus end strobe (owner or slave)
data_valid  in  1  bus data strobe, counts as activity
bus_error  in  1  slave-signalled bus error
lock  in  1  owner requests retention across transactions (used only with ARB_LOCK_EN)
arb_error  out  1  one-cycle pulse: arbiter-aborted transfer (timeout)
owner_id  out  3  index of current grantee, valid when bus_busy=1
bus_busy  out  1  high in GRANTED and TRANSFER

Behaviour:
- Reset (async, reset=0): bus_grant=0, arb_error=0, owner_id=0, bus_busy=0, state=IDLE, rr pointer=0, counters=0.
- States: IDLE, GRANTED, TRANSFER.
- IDLE: if any bus_request, winner = first set request searching from pointer upward with wrap (pointer, pointer+1 .. NUM_MASTERS-1, 0 ..). On that edge: bus_grant[winner]=1, owner_id=winner, bus_busy=1, state=GRANTED. Latency: request sampled at edge k -> grant visible after edge k (1 cycle). No request -> stays, outputs 0.
- GRANTED: begin_transaction -> TRANSFER. Owner drops bus_request -> IDLE. Wait counter reaches GRANT_WAIT_CYCLES without begin -> IDLE, arb_error pulse. All exits to IDLE clear bus_grant on the same edge.
- TRANSFER: end_transaction or bus_error -> IDLE, grant removed, pointer=owner_id+1 (wrap at NUM_MASTERS). Activity counter resets on begin_transaction/data_valid; reaching TIMEOUT_CYCLES -> IDLE, arb_error=1 for exactly one cycle, pointer advanced.
- Request drop during TRANSFER is ignored; grant held until end/error/timeout.
- At least one IDLE cycle between owners; the freed master may be regranted only if no other master requests (fairness).
- Simultaneous end_transaction and bus_error: treated as a single termination, no arb_error.
- Simultaneous timeout and end_transaction on the same edge: end wins, no arb_error.
- bus_grant never has more than one bit set; a grant never changes while bus_busy=1.
- Reset mid-transfer: grant drops immediately (asynchronous).

Optional Feature:
ARB_LOCK_EN: when defined, if lock=1 and the owner's bus_request=1 on the end_transaction edge, the FSM goes TRANSFER->GRANTED with the same owner. The grant stays high, the pointer does not advance and the wait counter reloads. bus_error or timeout always releases, regardless of lock. When not defined, the lock port is present but ignored and every transaction end releases the bus.

Test Plan:
- Reset release, req=4'b0000 for 5 cycles -> bus_grant=0, bus_busy=0, arb_error=0 throughout.
- req=4'b0010; begin 2 cycles after grant; end 6 cycles later -> grant=4'b0010 one cycle after request, owner_id=1, grant cleared on end edge, pointer=2.
- req=4'b1011 held with each owner completing a transaction -> grant order 0,1,3,0,1 (round-robin, no master starved).
- Owner granted, begin then no activity, TIMEOUT_CYCLES=8 -> arb_error single pulse 8 cycles after last activity, grant=0 the same edge, next requester granted 1 cycle later.
- Granted master never begins, GRANT_WAIT_CYCLES=15 -> release plus arb_error after 15 cycles; bus_error during TRANSFER -> release with no arb_error.
- ARB_LOCK_EN defined, master 2 holds lock=1, req=4'b0101 -> master 2 keeps grant across 3 transactions; lock=0 -> grant passes to master 0.
